// File: rtl/glove_pkg.sv
// Shared constants and state encodings for the glove frame receiver.
package glove_pkg;

   localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
   localparam logic [4:0] DEF_STATUS_ADDR = 5'd8;
   localparam logic [4:0] DEF_DATA_ADDR   = 5'd0;
   localparam int         DEF_RRDY_BIT    = 7;

   typedef enum logic [1:0] {S_IDLE, S_POLL, S_READ, S_GAP} bus_state_e;
   typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CKSUM} prs_state_e;

endpackage

// File: rtl/glove_frame_parser.sv
// Sync hunt and frame assembly from a byte strobe; holds the last good frame.
// GLOVE_RX_CHECKSUM_EN adds a trailing mod-256 checksum byte per frame.
module glove_frame_parser
   import glove_pkg::*;
#(
   parameter int         P         = 10,
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
   input  logic             avm_clk,
   input  logic             avm_rst,
   input  logic             abort_i,
   input  logic             byte_vld_i,
   input  logic [7:0]       byte_i,
   output logic [8*P-1:0]   frame_o,
   output logic             good_o,
   output logic             valid_o,
   output logic             err_o,
   output logic             busy_o
);

   localparam int IW = (P > 1) ? $clog2(P) : 1;

   prs_state_e         state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [8*P-1:0]     shadow_q, shadow_d;
   logic [8*P-1:0]     frame_q, frame_d;
   logic [7:0]         sum_q, sum_d;
   logic [8*P+7:0]     wide;
   logic               valid_q;
   logic               good;
`ifdef GLOVE_RX_CHECKSUM_EN
   logic               bad;
   logic               err_q;
`endif

   // Shadow shifts left so the first payload byte ends up in the top bits.
   assign wide = {shadow_q, byte_i};

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      sum_d    = sum_q;
      good     = 1'b0;
`ifdef GLOVE_RX_CHECKSUM_EN
      bad      = 1'b0;
`endif
      if (abort_i) begin
         state_d = P_HUNT;
      end else if (byte_vld_i) begin
         case (state_q)
            P_HUNT: begin
               if (byte_i == SYNC_BYTE) begin
                  state_d = P_PAYLOAD;
                  idx_d   = '0;
                  sum_d   = 8'd0;
               end
            end
            P_PAYLOAD: begin
               shadow_d = wide[8*P-1:0];
               sum_d    = sum_q + byte_i;
               idx_d    = idx_q + 1'b1;
               if (idx_q == IW'(P-1)) begin
`ifdef GLOVE_RX_CHECKSUM_EN
                  state_d = P_CKSUM;
`else
                  state_d = P_HUNT;
                  good    = 1'b1;
                  frame_d = wide[8*P-1:0];
`endif
               end
            end
`ifdef GLOVE_RX_CHECKSUM_EN
            P_CKSUM: begin
               state_d = P_HUNT;
               if (byte_i == sum_q) begin
                  good    = 1'b1;
                  frame_d = shadow_q;
               end else begin
                  bad = 1'b1;
               end
            end
`endif
            default: state_d = P_HUNT;
         endcase
      end
   end

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         state_q  <= P_HUNT;
         idx_q    <= '0;
         shadow_q <= '0;
         frame_q  <= '0;
         sum_q    <= 8'd0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         sum_q    <= sum_d;
         valid_q  <= good;
      end
   end

`ifdef GLOVE_RX_CHECKSUM_EN
   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) err_q <= 1'b0;
      else          err_q <= bad;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign frame_o = frame_q;
   assign good_o  = good;
   assign valid_o = valid_q;
   assign busy_o  = (state_q != P_HUNT);

endmodule

// File: rtl/glove_frame_rx.sv
// Avalon-MM poller for the RS232 UART feeding the glove frame parser.
// GLOVE_RX_CHECKSUM_EN enables per-frame checksum checking in the parser.
module glove_frame_rx
   import glove_pkg::*;
#(
   parameter int         NUM_CH       = 5,
   parameter int         BYTES_PER_CH = 2,
   parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
   parameter logic [4:0] STATUS_ADDR  = DEF_STATUS_ADDR,
   parameter logic [4:0] DATA_ADDR    = DEF_DATA_ADDR,
   parameter int         RRDY_BIT     = DEF_RRDY_BIT,
   localparam int        P            = NUM_CH * BYTES_PER_CH
) (
   input  logic             avm_clk,
   input  logic             avm_rst,
   input  logic             i_enable,
   output logic [4:0]       avm_address,
   output logic             avm_read,
   input  logic [31:0]      avm_readdata,
   input  logic             avm_waitrequest,
   output logic [8*P-1:0]   o_frame,
   output logic             o_frame_valid,
   output logic             o_frame_err,
   output logic [15:0]      o_frame_cnt,
   output logic             o_busy
);

   bus_state_e  st_q, st_d;
   logic [15:0] cnt_q;
   logic        byte_vld;
   logic        good;
   logic        unused_rd;

   assign unused_rd = ^avm_readdata;

   // Bus outputs decode straight from the state register, so reset drops
   // avm_read in the same cycle.
   always_comb begin
      st_d        = st_q;
      avm_read    = 1'b0;
      avm_address = STATUS_ADDR;
      byte_vld    = 1'b0;
      case (st_q)
         S_IDLE: if (i_enable) st_d = S_POLL;
         S_POLL: begin
            avm_read = 1'b1;
            if (!avm_waitrequest)
               st_d = (avm_readdata[RRDY_BIT] && i_enable) ? S_READ : S_GAP;
         end
         S_READ: begin
            avm_read    = 1'b1;
            avm_address = DATA_ADDR;
            if (!avm_waitrequest) begin
               byte_vld = i_enable;
               st_d     = S_GAP;
            end
         end
         S_GAP:   st_d = i_enable ? S_POLL : S_IDLE;
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         st_q  <= S_IDLE;
         cnt_q <= 16'd0;
      end else begin
         st_q <= st_d;
         if (good) cnt_q <= cnt_q + 16'd1;
      end
   end

   glove_frame_parser #(
      .P         (P),
      .SYNC_BYTE (SYNC_BYTE)
   ) u_parser (
      .avm_clk    (avm_clk),
      .avm_rst    (avm_rst),
      .abort_i    (!i_enable),
      .byte_vld_i (byte_vld),
      .byte_i     (avm_readdata[7:0]),
      .frame_o    (o_frame),
      .good_o     (good),
      .valid_o    (o_frame_valid),
      .err_o      (o_frame_err),
      .busy_o     (o_busy)
   );

   assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_glove_frame_rx.sv
// Directed bench for glove_frame_rx with a behavioural UART slave model.
module tb_glove_frame_rx;

   localparam int P = 10;

   logic           avm_clk = 1'b0;
   logic           avm_rst = 1'b0;
   logic           i_enable = 1'b0;
   logic [4:0]     avm_address;
   logic           avm_read;
   logic [31:0]    avm_readdata;
   logic           avm_waitrequest;
   logic [8*P-1:0] o_frame;
   logic           o_frame_valid;
   logic           o_frame_err;
   logic [15:0]    o_frame_cnt;
   logic           o_busy;

   glove_frame_rx dut (
      .avm_clk         (avm_clk),
      .avm_rst         (avm_rst),
      .i_enable        (i_enable),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .o_frame         (o_frame),
      .o_frame_valid   (o_frame_valid),
      .o_frame_err     (o_frame_err),
      .o_frame_cnt     (o_frame_cnt),
      .o_busy          (o_busy)
   );

   always #5 avm_clk = ~avm_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // UART slave: byte FIFO, programmable stall and initial status misses
   logic [7:0] mem [0:255];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         stall = 0;
   int         miss = 0;
   int         miss_used = 0;
   int         wcnt = 0;
   int         stab_err = 0;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         edge_n = 0;
   int         last_rd_edge = 0;
   int         lat = 0;
   logic [4:0] prev_addr = 5'd0;
   logic       prev_pend = 1'b0;

   always_comb begin
      avm_waitrequest = avm_read && (wcnt < stall);
      avm_readdata    = 32'd0;
      if (avm_address == 5'd8)
         avm_readdata[7] = (rd_ptr != wr_ptr) && (miss_used >= miss);
      else
         avm_readdata[7:0] = mem[rd_ptr[7:0]];
   end

   always @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         wcnt      <= 0;
         miss_used <= 0;
         prev_pend <= 1'b0;
      end else begin
         edge_n <= edge_n + 1;
         if (prev_pend && (avm_read !== 1'b1 || avm_address !== prev_addr))
            stab_err <= stab_err + 1;
         prev_pend <= avm_read && avm_waitrequest;
         prev_addr <= avm_address;
         if (avm_read && avm_waitrequest) begin
            wcnt <= wcnt + 1;
         end else if (avm_read) begin
            wcnt <= 0;
            if (avm_address == 5'd0) begin
               rd_ptr       <= rd_ptr + 1;
               last_rd_edge <= edge_n;
            end else if (miss_used < miss) begin
               miss_used <= miss_used + 1;
            end
         end
         if (o_frame_valid) begin
            valid_cnt <= valid_cnt + 1;
            lat       <= edge_n - last_rd_edge;
         end
         if (o_frame_err) err_cnt <= err_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic send_frame(input logic [8*P-1:0] f);
      logic [7:0] sum;
      logic [7:0] b;
      sum = 8'd0;
      push(8'hA5);
      for (int i = 0; i < P; i++) begin
         b = f[8*(P-1-i) +: 8];
         push(b);
         sum = sum + b;
      end
`ifdef GLOVE_RX_CHECKSUM_EN
      push(sum);
`endif
   endtask

   task automatic wait_frames(input int target, input string tag);
      int t;
      t = 0;
      while ((valid_cnt + err_cnt) < target && t < 3000) begin
         @(negedge avm_clk);
         t++;
      end
      check(tag, 128'(t < 3000), 128'd1);
   endtask

   initial begin
      int t;
      int nf;

      // reset values
      repeat (2) @(negedge avm_clk);
      check("rst_read", 128'(avm_read), 128'd0);
      check("rst_addr", 128'(avm_address), 128'd8);
      check("rst_frame", 128'(o_frame), 128'd0);
      check("rst_valid", 128'(o_frame_valid), 128'd0);
      check("rst_err", 128'(o_frame_err), 128'd0);
      check("rst_cnt", 128'(o_frame_cnt), 128'd0);
      check("rst_busy", 128'(o_busy), 128'd0);

      // async reset while a data read is stalled
      avm_rst = 1'b1;
      stall = 5;
      i_enable = 1'b1;
      push(8'hA5);
      t = 0;
      while (!(avm_read && avm_address == 5'd0 && avm_waitrequest) && t < 200) begin
         @(negedge avm_clk);
         t++;
      end
      check("reach_read", 128'(t < 200), 128'd1);
      avm_rst = 1'b0;
      miss = 3;
      #1;
      check("midrst_read", 128'(avm_read), 128'd0);
      check("midrst_addr", 128'(avm_address), 128'd8);
      check("midrst_busy", 128'(o_busy), 128'd0);
      stall = 0;
      @(negedge avm_clk);
      avm_rst = 1'b1;

      // three missed polls, then A5 01..0A
      for (int i = 1; i <= P; i++) push(8'(i));
`ifdef GLOVE_RX_CHECKSUM_EN
      push(8'h37);
`endif
      wait_frames(1, "wait_f1");
      check("f1_frame", 128'(o_frame), 128'(80'h0102030405060708090A));
      check("f1_cnt", 128'(o_frame_cnt), 128'd1);
      check("f1_pulses", 128'(valid_cnt), 128'd1);
      check("f1_lat", 128'(lat), 128'd1);

      // leading junk, in-payload sync value kept as data
      push(8'h33);
      send_frame(80'h11223344A566778899AA);
      wait_frames(2, "wait_f2");
      check("f2_frame", 128'(o_frame), 128'(80'h11223344A566778899AA));
      check("f2_cnt", 128'(o_frame_cnt), 128'd2);

      // five-cycle waitrequest on every read
      stall = 5;
      send_frame(80'h0102030405060708090A);
      wait_frames(3, "wait_f3");
      check("f3_frame", 128'(o_frame), 128'(80'h0102030405060708090A));
      check("f3_cnt", 128'(o_frame_cnt), 128'd3);
      check("f3_stable", 128'(stab_err), 128'd0);
      check("f3_lat", 128'(lat), 128'd1);
      stall = 0;
      nf = 3;

`ifdef GLOVE_RX_CHECKSUM_EN
      push(8'hA5);
      for (int i = 1; i <= P; i++) push(8'(i));
      push(8'h37);
      wait_frames(4, "wait_ck_ok");
      check("ck_ok_cnt", 128'(o_frame_cnt), 128'd4);
      check("ck_ok_pulses", 128'(valid_cnt), 128'd4);
      push(8'hA5);
      for (int i = 1; i <= P; i++) push(8'(8'h10 + i));
      push(8'h38);
      wait_frames(5, "wait_ck_bad");
      check("ck_bad_err", 128'(err_cnt), 128'd1);
      check("ck_bad_frame", 128'(o_frame), 128'(80'h0102030405060708090A));
      check("ck_bad_cnt", 128'(o_frame_cnt), 128'd4);
      check("ck_bad_pulses", 128'(valid_cnt), 128'd4);
      nf = 4;
`else
      check("no_err_pulse", 128'(err_cnt), 128'd0);
`endif

      // enable dropped after payload byte 3
      push(8'hA5);
      push(8'h01);
      push(8'h02);
      push(8'h03);
      t = 0;
      while (rd_ptr != wr_ptr && t < 500) begin
         @(negedge avm_clk);
         t++;
      end
      check("drain", 128'(t < 500), 128'd1);
      repeat (2) @(negedge avm_clk);
      check("part_busy", 128'(o_busy), 128'd1);
      i_enable = 1'b0;
      repeat (6) @(negedge avm_clk);
      check("abort_busy", 128'(o_busy), 128'd0);
      check("abort_read", 128'(avm_read), 128'd0);
      check("abort_pulses", 128'(valid_cnt), 128'(nf));

      force dut.cnt_q = 16'hFFFF;
      @(negedge avm_clk);
      release dut.cnt_q;
      @(negedge avm_clk);
      check("preset_cnt", 128'(o_frame_cnt), 128'hFFFF);

      for (int i = 4; i <= P; i++) push(8'(i));
      send_frame(80'hF0F1F2F3F4F5F6F7F8F9);
      i_enable = 1'b1;
      wait_frames(nf + 1, "wait_wrap");
      check("wrap_frame", 128'(o_frame), 128'(80'hF0F1F2F3F4F5F6F7F8F9));
      check("wrap_cnt", 128'(o_frame_cnt), 128'd0);
      check("wrap_pulses", 128'(valid_cnt), 128'(nf + 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
